// File: rtl/qbus_slave.sv
// qbus_slave: QBUS slave-cycle front end for a small synchronous register bank.
// Synchronises bus strobes and turns DATI/DATO(B)/DATIO(B) into one-cycle requests.
module qbus_slave #(
  parameter logic [12:0] BASE  = 13'o17760,
  parameter int          ABITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [21:0]      DAL_in,
  output logic [21:0]      DAL_out,
  output logic             DALtx,
  input  logic             RSYNC,
  input  logic             RDIN,
  input  logic             RDOUT,
  input  logic             RWTBT,
  input  logic             RBS7,
  input  logic             RINIT,
  output logic             TRPLY,
  output logic [ABITS-1:0] reg_addr,
  output logic             reg_rd,
  output logic             reg_wr,
  output logic [1:0]       reg_be,
  output logic [15:0]      reg_wdata,
  input  logic [15:0]      reg_rdata,
  input  logic             reg_ack
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    SEL,
    REQ,
    ACK,
    REPLY,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [1:0]  sync_ff;
  logic [1:0]  din_ff;
  logic [1:0]  dout_ff;
  logic [1:0]  wtbt_ff;
  logic [1:0]  init_ff;
  logic        s_sync;
  logic        s_din;
  logic        s_dout;
  logic        s_wtbt;
  logic        s_init;
  logic        sync_q;
  logic        din_q;
  logic        dout_q;
  logic        sync_rise;

  logic        page;
  logic [12:0] addr;
  logic        is_wr;
  logic        first;
  logic [15:0] rdata_q;
  logic        match;

  logic        ld_addr;
  logic        start_rd;
  logic        start_wr;
  logic        cap;

  logic        unused_dal;

  assign unused_dal = ^DAL_in[21:16];

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_ff <= '0;
      din_ff  <= '0;
      dout_ff <= '0;
      wtbt_ff <= '0;
      init_ff <= '0;
      sync_q  <= 1'b0;
      din_q   <= 1'b0;
      dout_q  <= 1'b0;
    end else begin
      sync_ff <= {sync_ff[0], RSYNC};
      din_ff  <= {din_ff[0], RDIN};
      dout_ff <= {dout_ff[0], RDOUT};
      wtbt_ff <= {wtbt_ff[0], RWTBT};
      init_ff <= {init_ff[0], RINIT};
      sync_q  <= s_sync;
      din_q   <= s_din;
      dout_q  <= s_dout;
    end
  end

  assign s_sync = sync_ff[1];
  assign s_din  = din_ff[1];
  assign s_dout = dout_ff[1];
  assign s_wtbt = wtbt_ff[1];
  assign s_init = init_ff[1];

  assign sync_rise = s_sync & ~sync_q;

  assign match = page &&
    (addr[12:ABITS+1] == BASE[12:ABITS+1]);

  always_ff @(posedge clk) begin
    if (reset || s_init) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Data strobes are acted on one cycle after synchronisation (din_q/dout_q),
  // while their release is seen straight from the synchroniser.
  always_comb begin
    nxt      = state;
    ld_addr  = 1'b0;
    start_rd = 1'b0;
    start_wr = 1'b0;
    cap      = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_rise) begin
          nxt     = ADDR;
          ld_addr = 1'b1;
        end
      end
      ADDR: begin
        if (!s_sync) begin
          nxt = IDLE;
        end else if (match) begin
          nxt = SEL;
        end
      end
      SEL: begin
        if (!s_sync) begin
          nxt = IDLE;
        end else if (din_q) begin
          nxt      = REQ;
          start_rd = 1'b1;
        end else if (dout_q) begin
          nxt      = REQ;
          start_wr = 1'b1;
        end
      end
      REQ, ACK: begin
        if (!s_sync) begin
          nxt = IDLE;
        end else if (reg_ack) begin
          nxt = REPLY;
          cap = ~is_wr;
        end else begin
          nxt = ACK;
        end
      end
      REPLY: begin
        if (is_wr ? !s_dout : !s_din) begin
          nxt = DONE;
        end
      end
      DONE: begin
        nxt = SEL;
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    reg_rd = 1'b0;
    reg_wr = 1'b0;
    DALtx  = 1'b0;
    TRPLY  = 1'b0;
    if (state == REQ) begin
      reg_rd = ~is_wr;
      reg_wr = is_wr;
    end
    if (state == REPLY) begin
      DALtx = ~is_wr;
      TRPLY = is_wr | ~first;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || s_init) begin
      page      <= 1'b0;
      addr      <= '0;
      is_wr     <= 1'b0;
      first     <= 1'b0;
      rdata_q   <= '0;
      reg_be    <= '0;
      reg_wdata <= '0;
    end else begin
      first <= (state != REPLY);
      if (ld_addr) begin
        page <= RBS7;
        addr <= DAL_in[12:0];
      end
      if (start_rd) begin
        is_wr <= 1'b0;
      end
      if (start_wr) begin
        is_wr     <= 1'b1;
        reg_wdata <= DAL_in[15:0];
        if (s_wtbt) begin
          reg_be <= addr[0] ? 2'b10 : 2'b01;
        end else begin
          reg_be <= 2'b11;
        end
      end
      if (cap) begin
        rdata_q <= reg_rdata;
      end
    end
  end

  assign reg_addr = addr[ABITS:1];
  assign DAL_out  = {6'b0, rdata_q};

endmodule

// File: tb/tb_qbus_slave.sv
// tb_qbus_slave: table-driven bus cycles with a request scoreboard
// and hand-written INIT / abandoned-cycle sequences.
module tb_qbus_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic [21:0] DAL_in;
  logic [21:0] DAL_out;
  logic        DALtx;
  logic        RSYNC;
  logic        RDIN;
  logic        RDOUT;
  logic        RWTBT;
  logic        RBS7;
  logic        RINIT;
  logic        TRPLY;
  logic [2:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [1:0]  reg_be;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        reg_ack;

  qbus_slave #(.BASE(13'o17760), .ABITS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .DAL_in    (DAL_in),
    .DAL_out   (DAL_out),
    .DALtx     (DALtx),
    .RSYNC     (RSYNC),
    .RDIN      (RDIN),
    .RDOUT     (RDOUT),
    .RWTBT     (RWTBT),
    .RBS7      (RBS7),
    .RINIT     (RINIT),
    .TRPLY     (TRPLY),
    .reg_addr  (reg_addr),
    .reg_rd    (reg_rd),
    .reg_wr    (reg_wr),
    .reg_be    (reg_be),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] addr;
    logic        bs7;
    int          kind;
    logic [15:0] data;
    int          ack_d;
    logic        hit;
    logic [2:0]  ra;
    logic [1:0]  be;
    int          lat;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [2:0]  a;
    logic [1:0]  be;
    logic [15:0] d;
  } req_t;

  vec_t vecs[8];
  req_t exp_q[$];

  int   tests = 0;
  int   fails = 0;
  int   n_rd = 0;
  int   n_wr = 0;
  int   n_trply = 0;
  int   n_daltx = 0;
  int   ack_delay = 0;
  logic ack_hold = 1'b0;
  logic ack_force = 1'b0;
  logic ack_drv = 1'b0;

  assign reg_ack = ack_force | ack_drv |
    (!ack_hold && ack_delay == 0 && (reg_rd | reg_wr));

  function automatic void chk(input string name,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h, want 'h%0h", name, act, exp);
    end
  endfunction

  task automatic responder();
    int w;
    w = 0;
    forever begin
      @(negedge clk);
      ack_drv = 1'b0;
      if (w > 0) begin
        w--;
        if (w == 0 && !ack_hold) ack_drv = 1'b1;
      end
      if ((reg_rd | reg_wr) && ack_delay > 0) w = ack_delay;
    end
  endtask

  task automatic monitor();
    req_t        r;
    logic        cur_rd;
    logic [15:0] cur_d;
    logic        tp;
    logic        dp;
    logic        qp;
    cur_rd = 1'b0;
    cur_d  = '0;
    tp     = 1'b0;
    dp     = 1'b0;
    qp     = 1'b0;
    forever begin
      @(negedge clk);
      if (reg_rd | reg_wr) begin
        n_rd += int'(reg_rd);
        n_wr += int'(reg_wr);
        chk("req_width", {31'b0, qp}, 0);
        chk("req_onehot", {31'b0, reg_rd & reg_wr}, 0);
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_req: rd=%0b wr=%0b addr=%0d",
                   reg_rd, reg_wr, reg_addr);
        end else begin
          r = exp_q.pop_front();
          chk("req_kind", {31'b0, reg_wr}, {31'b0, r.wr});
          chk("reg_addr", {29'b0, reg_addr}, {29'b0, r.a});
          if (r.wr) begin
            chk("reg_be", {30'b0, reg_be}, {30'b0, r.be});
            chk("reg_wdata", {16'b0, reg_wdata}, {16'b0, r.d});
          end
          cur_rd = ~r.wr;
          cur_d  = r.d;
        end
      end
      if (TRPLY && !tp) begin
        n_trply++;
        if (cur_rd) begin
          chk("daltx_lead", {31'b0, dp}, 1);
          chk("dal_out", {10'b0, DAL_out}, {16'b0, cur_d});
        end else begin
          chk("daltx_on_wr", {31'b0, DALtx}, 0);
        end
      end
      if (DALtx && !dp) n_daltx++;
      if (dp && !DALtx) chk("daltx_drop", {31'b0, TRPLY}, 0);
      tp = TRPLY;
      dp = DALtx;
      qp = reg_rd | reg_wr;
    end
  endtask

  task automatic wait_trply(input logic lvl, input int lim,
                            output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      n++;
      if (TRPLY === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic addr_phase(input logic [21:0] a, input logic b);
    @(negedge clk);
    DAL_in = a;
    RBS7   = b;
    RSYNC  = 1'b1;
    repeat (5) @(negedge clk);
    DAL_in = '0;
    RBS7   = 1'b0;
  endtask

  task automatic data_phase(input int kind, input logic [15:0] d,
                            input int ackd, input logic hit,
                            input logic [2:0] ra, input logic [1:0] be,
                            input int lat);
    req_t r;
    int   n;
    bit   ok;
    ack_delay = ackd;
    if (hit) begin
      r.wr = (kind != 0);
      r.a  = ra;
      r.be = be;
      r.d  = d;
      exp_q.push_back(r);
    end
    if (kind == 0) begin
      reg_rdata = d;
      RDIN      = 1'b1;
    end else begin
      DAL_in = {6'b0, d};
      RWTBT  = (kind == 2);
      RDOUT  = 1'b1;
    end
    wait_trply(1'b1, hit ? 40 : 15, n, ok);
    if (hit) begin
      chk("reply_seen", {31'b0, ok}, 1);
      if (ok) chk("assert_lat", n, lat);
    end else begin
      chk("no_reply", {31'b0, ok}, 0);
    end
    RDIN  = 1'b0;
    RDOUT = 1'b0;
    if (hit && ok) begin
      wait_trply(1'b0, 20, n, ok);
      chk("drop_lat", n, 3);
    end
    RWTBT  = 1'b0;
    DAL_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic end_cycle();
    RSYNC = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic run_row(input vec_t v);
    int rd0;
    int wr0;
    int tr0;
    int dx0;
    addr_phase(v.addr, v.bs7);
    rd0 = n_rd;
    wr0 = n_wr;
    tr0 = n_trply;
    dx0 = n_daltx;
    data_phase(v.kind, v.data, v.ack_d, v.hit, v.ra, v.be, v.lat);
    end_cycle();
    chk("n_rd", n_rd - rd0, (v.hit && v.kind == 0) ? 1 : 0);
    chk("n_wr", n_wr - wr0, (v.hit && v.kind != 0) ? 1 : 0);
    chk("n_trply", n_trply - tr0, v.hit ? 1 : 0);
    chk("n_daltx", n_daltx - dx0, (v.hit && v.kind == 0) ? 1 : 0);
  endtask

  initial begin
    req_t r;
    int   rd0;
    int   wr0;
    int   tr0;
    int   dx0;
    int   n;
    bit   ok;

    vecs[0] = '{22'o17762, 1'b1, 0, 16'o123456, 2, 1'b1, 3'd1, 2'b00, 8};
    vecs[1] = '{22'o17765, 1'b1, 2, 16'o177400, 0, 1'b1, 3'd2, 2'b10, 5};
    vecs[2] = '{22'o17700, 1'b1, 0, 16'o111111, 0, 1'b0, 3'd0, 2'b00, 0};
    vecs[3] = '{22'o17760, 1'b0, 1, 16'o000777, 0, 1'b0, 3'd0, 2'b00, 0};
    vecs[4] = '{22'o17776, 1'b1, 0, 16'o000001, 0, 1'b1, 3'd7, 2'b00, 6};
    vecs[5] = '{22'o17770, 1'b1, 1, 16'o052525, 1, 1'b1, 3'd4, 2'b11, 6};
    vecs[6] = '{22'o17760, 1'b1, 2, 16'o000377, 0, 1'b1, 3'd0, 2'b01, 5};
    vecs[7] = '{22'o17774, 1'b1, 0, 16'o177777, 3, 1'b1, 3'd6, 2'b00, 9};

    reset     = 1'b1;
    DAL_in    = '0;
    RSYNC     = 1'b0;
    RDIN      = 1'b0;
    RDOUT     = 1'b0;
    RWTBT     = 1'b0;
    RBS7      = 1'b0;
    RINIT     = 1'b0;
    reg_rdata = '0;

    fork
      responder();
      monitor();
    join_none

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_trply", {31'b0, TRPLY}, 0);
    chk("rst_daltx", {31'b0, DALtx}, 0);
    chk("rst_rdwr", {30'b0, reg_rd, reg_wr}, 0);
    chk("rst_addr", {29'b0, reg_addr}, 0);
    chk("rst_be", {30'b0, reg_be}, 0);
    chk("rst_wdata", {16'b0, reg_wdata}, 0);
    chk("rst_dal", {10'b0, DAL_out}, 0);

    for (int i = 0; i < 8; i++) begin
      run_row(vecs[i]);
    end

    // DATIO: read then write inside one SYNC
    addr_phase(22'o17760, 1'b1);
    rd0 = n_rd;
    wr0 = n_wr;
    tr0 = n_trply;
    dx0 = n_daltx;
    data_phase(0, 16'o007070, 0, 1'b1, 3'd0, 2'b00, 6);
    data_phase(1, 16'o125252, 0, 1'b1, 3'd0, 2'b11, 5);
    end_cycle();
    chk("datio_rd", n_rd - rd0, 1);
    chk("datio_wr", n_wr - wr0, 1);
    chk("datio_trply", n_trply - tr0, 2);
    chk("datio_daltx", n_daltx - dx0, 1);

    // INIT during the reply of a read
    addr_phase(22'o17762, 1'b1);
    ack_delay = 0;
    reg_rdata = 16'o004321;
    r.wr = 1'b0;
    r.a  = 3'd1;
    r.be = 2'b00;
    r.d  = 16'o004321;
    exp_q.push_back(r);
    RDIN = 1'b1;
    wait_trply(1'b1, 40, n, ok);
    chk("init_reply_seen", {31'b0, ok}, 1);
    RINIT = 1'b1;
    repeat (3) @(negedge clk);
    chk("init_trply", {31'b0, TRPLY}, 0);
    chk("init_daltx", {31'b0, DALtx}, 0);
    chk("init_addr", {29'b0, reg_addr}, 0);
    chk("init_dal", {10'b0, DAL_out}, 0);
    RINIT = 1'b0;
    RDIN  = 1'b0;
    end_cycle();
    run_row(vecs[0]);

    // SYNC dropped while the register bank withholds ack
    addr_phase(22'o17762, 1'b1);
    ack_delay = 0;
    ack_hold  = 1'b1;
    rd0 = n_rd;
    tr0 = n_trply;
    dx0 = n_daltx;
    r.wr = 1'b0;
    r.a  = 3'd1;
    r.be = 2'b00;
    r.d  = 16'o000000;
    exp_q.push_back(r);
    RDIN = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_rd != rd0) break;
    end
    chk("abort_req", n_rd - rd0, 1);
    RSYNC = 1'b0;
    RDIN  = 1'b0;
    repeat (6) @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    repeat (4) @(negedge clk);
    ack_hold = 1'b0;
    chk("abort_trply", n_trply - tr0, 0);
    chk("abort_daltx", n_daltx - dx0, 0);
    chk("abort_idle", {30'b0, TRPLY, DALtx}, 0);
    run_row(vecs[4]);
    run_row(vecs[5]);

    chk("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
